execute_stage: RTL and testbench

- Combinational ALU and condition logic of the Y86-64 pipeline Execute stage, plus the sequential condition-code (CC) register.
- Consumes the E_* outputs of the execute pipeline register and the stat fields of the later stages.
- Produces e_valE, e_dstE and e_Cnd for the memory pipeline register and for the forwarding logic.
- The CC register updates on clk only for a non-squashed OPq.

---
 rtl/execute_stage.sv | 113 +++++++++++
 tb/tb_execute_stage.sv | 122 ++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Y86-64 Execute stage: ALU operand selection, ALU, condition evaluation and the
// condition-code register that only a committed, non-squashed OPq may update.
module execute_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  E_stat,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [63:0] E_valC,
  input  logic [63:0] E_valA,
  input  logic [63:0] E_valB,
  input  logic [3:0]  E_dstE,
  input  logic [2:0]  m_stat,
  input  logic [2:0]  W_stat,
  output logic [63:0] e_valE,
  output logic [3:0]  e_dstE,
  output logic        e_Cnd,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of
);
  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [2:0] STAT_AOK = 3'd1;

  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // E_stat is consumed by the stage above; only later-stage status gates CC.
  logic unused_e_stat;
  assign unused_e_stat = ^E_stat;

  logic [2:0]  cc_q, cc_d;  // {zf, sf, of}
  logic [63:0] alu_a, alu_b, alu_t;
  logic [3:0]  alufun;
  logic        zf, sf, of_flag, set_cc;

  always_comb begin
    alu_a = 64'd0;
    unique case (E_icode)
      I_RRMOVQ, I_OPQ:              alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:              alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:                alu_a = 64'd8;
      default:                      alu_a = 64'd0;
    endcase

    alu_b = 64'd0;
    unique case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
      default:                                                   alu_b = 64'd0;
    endcase

    alufun = (E_icode == I_OPQ) ? E_ifun : 4'd0;

    alu_t   = 64'd0;
    of_flag = 1'b0;
    unique case (alufun)
      4'd0: begin
        alu_t   = alu_b + alu_a;
        of_flag = (alu_a[63] == alu_b[63]) && (alu_t[63] != alu_a[63]);
      end
      4'd1: begin
        alu_t   = alu_b - alu_a;
        of_flag = (alu_a[63] != alu_b[63]) && (alu_t[63] != alu_b[63]);
      end
      4'd2:    alu_t = alu_b & alu_a;
      4'd3:    alu_t = alu_b ^ alu_a;
      default: alu_t = 64'd0;
    endcase
    zf = (alu_t == 64'd0);
    sf = alu_t[63];

    set_cc = (E_icode == I_OPQ) && (E_ifun <= 4'd3) &&
             (m_stat == STAT_AOK) && (W_stat == STAT_AOK);
    cc_d = set_cc ? {zf, sf, of_flag} : cc_q;
  end

  // Condition evaluation uses only the registered flags: no same-cycle bypass.
  always_comb begin
    e_Cnd = 1'b0;
    if (E_icode == I_RRMOVQ || E_icode == I_JXX) begin
      unique case (E_ifun)
        4'd0:    e_Cnd = 1'b1;
        4'd1:    e_Cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
        4'd2:    e_Cnd = cc_q[1] ^ cc_q[0];
        4'd3:    e_Cnd = cc_q[2];
        4'd4:    e_Cnd = !cc_q[2];
        4'd5:    e_Cnd = !(cc_q[1] ^ cc_q[0]);
        4'd6:    e_Cnd = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
        default: e_Cnd = 1'b0;
      endcase
    end
    e_valE = alu_t;
    e_dstE = (E_icode == I_RRMOVQ && !e_Cnd) ? RNONE : E_dstE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cc_q <= 3'b100;
    else        cc_q <= cc_d;
  end

  assign cc_zf = cc_q[2];
  assign cc_sf = cc_q[1];
  assign cc_of = cc_q[0];
endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage: the driver pushes hand-computed
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  E_stat = 3'd1;
  logic [3:0]  E_icode = 4'h1, E_ifun = 4'h0, E_dstE = 4'hF;
  logic [63:0] E_valC = '0, E_valA = '0, E_valB = '0;
  logic [2:0]  m_stat = 3'd1, W_stat = 3'd1;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd, cc_zf, cc_sf, cc_of;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE),
    .m_stat(m_stat), .W_stat(W_stat), .e_valE(e_valE), .e_dstE(e_dstE),
    .e_Cnd(e_Cnd), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard: {valE[71:8], dstE[7:4], cnd[3], cc{zf,sf,of}[2:0]}
  localparam int W = 72;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         chk_en = 1'b0;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: output presented with empty expected queue");
      end else begin
        logic [W-1:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, "valE", e_valE, e[71:8]);
        check(nm, "dstE", {60'd0, e_dstE}, {60'd0, e[7:4]});
        check(nm, "cnd", {63'd0, e_Cnd}, {63'd0, e[3]});
        check(nm, "cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, e[2:0]});
      end
    end
  end

  // Driver
  task automatic apply(input string nm, input logic r, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                       input logic [3:0] dst, input logic [2:0] ms, input logic [2:0] ws,
                       input logic [63:0] x_val, input logic [3:0] x_dst, input logic x_cnd,
                       input logic [2:0] x_cc);
    @(posedge clk);
    #1;
    rst_n = r; E_icode = ic; E_ifun = fn; E_valA = va; E_valB = vb; E_valC = vc;
    E_dstE = dst; m_stat = ms; W_stat = ws;
    E_stat = 3'd1 + 3'($urandom_range(0, 3));
    exp_q.push_back({x_val, x_dst, x_cnd, x_cc});
    name_q.push_back(nm);
    chk_en = 1'b1;
  endtask

  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    // Reset held across two edges; check during the second reset cycle.
    rst_n = 1'b0;
    @(posedge clk);
    apply("rst_je",    0, 4'h7, 4'h3, 0, 0, 0, 4'hF, 1, 1, 64'h0, 4'hF, 1, 3'b100);
    apply("post_rst",  1, 4'h7, 4'h3, 0, 0, 0, 4'hF, 1, 1, 64'h0, 4'hF, 1, 3'b100);
    apply("add_ovf",   1, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4'h2, 1, 1,
          64'h8000_0000_0000_0000, 4'h2, 0, 3'b100);
    apply("jl_ovf",    1, 4'h7, 4'h2, 0, 0, 0, 4'hF, 1, 1, 64'h0, 4'hF, 0, 3'b011);
    apply("sub_zero",  1, 4'h6, 4'h1, 64'd5, 64'd5, 0, 4'h3, 1, 1, 64'h0, 4'h3, 0, 3'b011);
    apply("cmovle",    1, 4'h2, 4'h1, 64'h1234, 0, 0, 4'h3, 1, 1, 64'h1234, 4'h3, 1, 3'b100);
    apply("cmovne",    1, 4'h2, 4'h4, 64'h1234, 0, 0, 4'h3, 1, 1, 64'h1234, 4'hF, 0, 3'b100);
    apply("pushq",     1, 4'hA, 4'h0, 64'h55, 64'h100, 0, 4'h4, 1, 1, 64'hF8, 4'h4, 0, 3'b100);
    apply("popq",      1, 4'hB, 4'h0, 64'h55, 64'h100, 0, 4'h4, 1, 1, 64'h108, 4'h4, 0, 3'b100);
    apply("xor_madr",  1, 4'h6, 4'h3, 64'hF0, 64'h0F, 0, 4'h1, 3, 1, 64'hFF, 4'h1, 0, 3'b100);
    apply("xor_wins",  1, 4'h6, 4'h3, 64'hF0, 64'h0F, 0, 4'h1, 1, 4, 64'hFF, 4'h1, 0, 3'b100);
    apply("xor_aok",   1, 4'h6, 4'h3, 64'hF0, 64'h0F, 0, 4'h1, 1, 1, 64'hFF, 4'h1, 0, 3'b100);
    apply("jne",       1, 4'h7, 4'h4, 0, 0, 0, 4'hF, 1, 1, 64'h0, 4'hF, 1, 3'b000);
    apply("op_badfun", 1, 4'h6, 4'h5, 64'h3, 64'h3, 0, 4'h1, 1, 1, 64'h0, 4'h1, 0, 3'b000);
    apply("je_hold",   1, 4'h7, 4'h3, 0, 0, 0, 4'hF, 1, 1, 64'h0, 4'hF, 0, 3'b000);
    apply("and_m0",    1, 4'h6, 4'h2, 64'h0, 64'hAB, 0, 4'h1, 0, 1, 64'h0, 4'h1, 0, 3'b000);
    apply("bubble",    1, 4'h1, 4'h0, 64'h7, 64'h7, 0, 4'hF, 1, 1, 64'h0, 4'hF, 0, 3'b000);
    apply("sub_rst",   0, 4'h6, 4'h1, 64'd1, 64'd0, 0, 4'h2, 1, 1, M1, 4'h2, 0, 3'b000);
    apply("jg_rst",    1, 4'h7, 4'h6, 0, 0, 0, 4'hF, 1, 1, 64'h0, 4'hF, 0, 3'b100);
    apply("call",      1, 4'h8, 4'h0, 0, 64'h200, 0, 4'h4, 1, 1, 64'h1F8, 4'h4, 0, 3'b100);
    apply("irmovq",    1, 4'h3, 4'h0, 0, 64'h99, 64'hDEAD, 4'h6, 1, 1, 64'hDEAD, 4'h6, 0, 3'b100);
    apply("jbadfun",   1, 4'h7, 4'h7, 0, 0, 0, 4'hF, 1, 1, 64'h0, 4'hF, 0, 3'b100);
    apply("rrmovq",    1, 4'h2, 4'h0, 64'h77, 0, 0, 4'h5, 1, 1, 64'h77, 4'h5, 1, 3'b100);
    apply("sub_ovf",   1, 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 0, 4'h2, 1, 1,
          64'h7FFF_FFFF_FFFF_FFFF, 4'h2, 0, 3'b100);
    apply("jl_subovf", 1, 4'h7, 4'h2, 0, 0, 0, 4'hF, 1, 1, 64'h0, 4'hF, 1, 3'b001);
    apply("jge",       1, 4'h7, 4'h5, 0, 0, 0, 4'hF, 1, 1, 64'h0, 4'hF, 0, 3'b001);
    apply("ret",       1, 4'h9, 4'h0, 0, 64'h1F8, 0, 4'h4, 1, 1, 64'h200, 4'h4, 0, 3'b001);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    repeat (2) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d expected 0 entries left", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
